// File: rtl/sync_fifo_reader.sv
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer, so the stream can run at one word per cycle.
module sync_fifo_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic             pop;
    logic [2:0]       level;

    always_comb begin
        m_valid  = (occ_q != OCC_EMPTY);
        m_data   = head_q;
        busy     = m_valid || inflight_q;
        rd_count = rd_count_q;
        pop      = m_valid && m_ready;
    end

    always_comb begin
        // Occupancy the buffer will have next cycle; a read is only issued if its
        // word is guaranteed a free slot when it lands.
        level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        r_en       = rst && en && !empty && (level < 3'd2);

        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = r_en;
        rd_count_d = rd_count_q;
        if (pop) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end

        unique case (occ_q)
            OCC_EMPTY: begin
                if (inflight_q) begin
                    head_d = data_out;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                unique case ({inflight_q, pop})
                    2'b10: begin
                        tail_d = data_out;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    2'b11: head_d = data_out;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (inflight_q) begin
                        tail_d = data_out;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            rd_count_q <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rd_count_q <= rd_count_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(occ_q == OCC_TWO && inflight_q && !pop));

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench: behavioural FIFO with one-cycle read latency feeds the reader;
// a negedge monitor records reads and downstream transfers.
module tb_sync_fifo_reader;

    logic       clk;
    logic       rst;
    logic       en;
    logic       empty;
    logic [7:0] data_out;
    logic       r_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       busy;
    logic [15:0] rd_count;

    logic       r_en_s;
    logic       m_valid_s;
    logic [7:0] m_data_s;
    logic       busy_s;
    logic [3:0] rd_count_s;

    sync_fifo_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .data_out(data_out),
        .r_en(r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .rd_count(rd_count)
    );

    // Narrow counter copy on identical stimulus to exercise counter wrap quickly.
    sync_fifo_reader #(.WIDTH(8), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .data_out(data_out),
        .r_en(r_en_s), .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s),
        .busy(busy_s), .rd_count(rd_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (r_en) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got [0:63];
    int pop_cyc [0:63];
    int ngot = 0;
    int nren = 0;
    int ren_first = 0;
    int ren_last = 0;
    int bad_ren = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready && ngot < 64) begin
            got[ngot]     = m_data;
            pop_cyc[ngot] = cyc;
            ngot++;
        end
        if (r_en) begin
            if (nren == 0) ren_first = cyc;
            ren_last = cyc;
            nren++;
        end
        if (r_en && empty) bad_ren++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr++;
    endtask

    task automatic clr();
        ngot = 0;
        nren = 0;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; m_ready = 1'b0;
        step(2);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_count", rd_count, 0);

        // Single word; r_en must stay low while rst is low even with data waiting.
        clr();
        push(8'hA5); en = 1'b1; m_ready = 1'b1;
        #1;
        check("rst_gates_r_en", r_en, 0);
        step(1);
        rst = 1'b1;
        #1;
        check("single_r_en_first", r_en, 1);
        step(1);
        check("single_r_en_off", r_en, 0);
        check("single_valid_n1", m_valid, 0);
        check("single_busy_n1", busy, 1);
        step(1);
        check("single_valid_n2", m_valid, 1);
        check("single_data_n2", m_data, 8'hA5);
        step(1);
        check("single_valid_done", m_valid, 0);
        check("single_rd_count", rd_count, 1);
        check("single_busy_done", busy, 0);
        check("single_nren", nren, 1);

        // Streaming eight words.
        en = 1'b0;
        reset_pulse();
        clr();
        for (int i = 1; i <= 8; i++) push(8'(i));
        en = 1'b1; m_ready = 1'b1;
        step(14);
        check("stream_nren", nren, 8);
        check("stream_ren_consec", ren_last - ren_first, 7);
        check("stream_ngot", ngot, 8);
        for (int i = 0; i < 8; i++) check($sformatf("stream_word%0d", i), got[i], i + 1);
        check("stream_pop_consec", pop_cyc[7] - pop_cyc[0], 7);
        check("stream_rd_count", rd_count, 8);
        check("stream_busy", busy, 0);

        // Backpressure.
        en = 1'b0;
        reset_pulse();
        clr();
        push(8'h10); push(8'h11); push(8'h12);
        en = 1'b1; m_ready = 1'b0;
        step(5);
        check("bp_nren", nren, 2);
        check("bp_r_en", r_en, 0);
        check("bp_valid", m_valid, 1);
        check("bp_data_held", m_data, 8'h10);
        check("bp_ngot", ngot, 0);
        m_ready = 1'b1;
        step(8);
        check("bp_ngot_after", ngot, 3);
        check("bp_word0", got[0], 8'h10);
        check("bp_word1", got[1], 8'h11);
        check("bp_word2", got[2], 8'h12);
        check("bp_nren_after", nren, 3);
        check("bp_rd_count", rd_count, 3);

        // Empty FIFO throughout.
        en = 1'b0;
        reset_pulse();
        clr();
        en = 1'b1; m_ready = 1'b1;
        step(10);
        check("empty_nren", nren, 0);
        check("empty_valid", m_valid, 0);
        check("empty_busy", busy, 0);

        // en dropped the cycle after the read.
        clr();
        push(8'h20); push(8'h21);
        en = 1'b1; m_ready = 1'b1;
        step(1);
        en = 1'b0;
        step(5);
        check("endrop_nren", nren, 1);
        check("endrop_ngot", ngot, 1);
        check("endrop_word", got[0], 8'h20);
        check("endrop_busy", busy, 0);
        check("endrop_r_en", r_en, 0);
        check("endrop_fifo_left", empty, 0);

        // Reset with the buffer full.
        clr();
        push(8'h30); push(8'h31);
        en = 1'b1; m_ready = 1'b0;
        step(5);
        check("midrst_nren", nren, 2);
        check("midrst_valid_pre", m_valid, 1);
        check("midrst_data_pre", m_data, 8'h21);
        check("midrst_count_pre", rd_count, 1);
        rst = 1'b0; en = 1'b0;
        step(1);
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_count", rd_count, 0);
        check("midrst_data", m_data, 0);
        check("midrst_r_en", r_en, 0);
        rst = 1'b1;
        #1;

        // Seventeen transfers: wraps the 4-bit counter copy past its maximum.
        clr();
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        en = 1'b1; m_ready = 1'b1;
        step(24);
        check("wrap_ngot", ngot, 17);
        check("wrap_first_word", got[0], 8'h31);
        check("wrap_last_word", got[16], 8'h4F);
        check("wrap_rd_count", rd_count, 17);
        check("wrap_small_count", rd_count_s, 1);
        check("wrap_busy", busy, 0);

        check("no_read_when_empty", bad_ren, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
